// File: rtl/spike_dispatch.sv
// ---------------------------------------------------------------------------
// spike_dispatch
//   Drains the SRAM-backed spike queue one neuron ID at a time. Each popped ID
//   is expanded into FANOUT consecutive synapse/weight addresses:
//      BASE_ADDR + id*FANOUT + j   (j = 0 .. FANOUT-1, taken mod 2^ADDR_W)
//   The addresses go to the weight-fetch stage over a valid/ready handshake.
//   A one-cycle done_o pulse is raised once the queue is empty and the last
//   address has been accepted.
//
// Ports
//   clk            in   1       system clock
//   rst            in   1       synchronous, active-high reset
//   start_i        in   1       begin draining (only honoured in IDLE)
//   queue_valid_i  in   1       queue holds at least one ID
//   queue_read_o   out  1       one-cycle pop strobe to the queue
//   queue_data_i   in   8       head data from the queue SRAM read port
//   addr_o         out  ADDR_W  synapse address to downstream
//   valid_o        out  1       addr_o is valid
//   ready_i        in   1       downstream accepts addr_o
//   busy_o         out  1       high whenever not IDLE
//   done_o         out  1       one-cycle pulse at end of drain
//   spike_count_o  out  16      IDs popped since last start (saturating)
// ---------------------------------------------------------------------------
module spike_dispatch #(
   parameter int                FANOUT       = 16,
   parameter int                ADDR_W       = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
   parameter int                READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              queue_valid_i,
   output logic              queue_read_o,
   input  logic [7:0]        queue_data_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [15:0]       spike_count_o
);

   localparam int J_W    = (FANOUT > 1) ? $clog2(FANOUT) : 1;
   localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam int PROD_W = 8 + $clog2(FANOUT);
   localparam int SUM_W  = ((PROD_W > ADDR_W) ? PROD_W : ADDR_W) + 2;

   localparam logic [J_W-1:0]   J_LAST   = J_W'(FANOUT - 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_WAIT,
      S_EMIT,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [7:0]        r_idQ;
   logic [J_W-1:0]    r_j;
   logic [LAT_W-1:0]  r_latCnt;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_spikeCount;

   // The id*FANOUT product is formed at its full natural width first, then the
   // sum with the base and the fanout index is truncated to the address width,
   // so wrap-around behaves as plain modular arithmetic.
   function automatic logic [ADDR_W-1:0] addrOf(input logic [7:0]     id,
                                                input logic [J_W-1:0] j);
      logic [PROD_W-1:0] prod;
      logic [SUM_W-1:0]  sum;
      prod = PROD_W'(id) * PROD_W'(FANOUT);
      sum  = SUM_W'(BASE_ADDR) + SUM_W'(prod) + SUM_W'(j);
      return sum[ADDR_W-1:0];
   endfunction

   // State register. Reset aborts any drain in progress and drops back to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and Moore outputs. Pops are only ever issued from POP, and POP
   // is only entered after queue_valid_i was seen high, so a read strobe can
   // never hit an empty queue and only one pop is ever in flight.
   always_comb begin
      w_nextState  = r_state;
      queue_read_o = 1'b0;
      valid_o      = 1'b0;
      busy_o       = 1'b1;
      done_o       = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (start_i) begin
               w_nextState = queue_valid_i ? S_POP : S_DONE;
            end
         end
         S_POP: begin
            queue_read_o = 1'b1;
            w_nextState  = S_WAIT;
         end
         S_WAIT: begin
            if (r_latCnt == LAT_LAST) begin
               w_nextState = S_EMIT;
            end
         end
         S_EMIT: begin
            valid_o = 1'b1;
            if (ready_i && (r_j == J_LAST)) begin
               w_nextState = queue_valid_i ? S_POP : S_DONE;
            end
         end
         S_DONE: begin
            done_o      = 1'b1;
            w_nextState = S_IDLE;
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Datapath. The address register is loaded with the j=0 address while the
   // queue data is captured, and advanced on every non-final handshake, so a
   // stalled address stays put and back-to-back handshakes give one address
   // per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idQ        <= '0;
         r_j          <= '0;
         r_latCnt     <= '0;
         r_addr       <= '0;
         r_spikeCount <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_spikeCount <= '0;
               end
            end
            S_POP: begin
               if (r_spikeCount != 16'hFFFF) begin
                  r_spikeCount <= r_spikeCount + 16'd1;
               end
               r_latCnt <= '0;
            end
            S_WAIT: begin
               if (r_latCnt == LAT_LAST) begin
                  r_idQ  <= queue_data_i;
                  r_j    <= '0;
                  r_addr <= addrOf(queue_data_i, J_W'(0));
               end else begin
                  r_latCnt <= r_latCnt + LAT_W'(1);
               end
            end
            S_EMIT: begin
               if (ready_i && (r_j != J_LAST)) begin
                  r_j    <= r_j + J_W'(1);
                  r_addr <= addrOf(r_idQ, r_j + J_W'(1));
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign addr_o        = r_addr;
   assign spike_count_o = r_spikeCount;

endmodule
